// File: rtl/ffe_pkg.sv
// Shared types and default sizing for the time-multiplexed FFE controller
// and its round/saturate helper.
package ffe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MAC   = 2'd2,
        OUT   = 2'd3
    } ffe_state_e;

    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_NUM_TAPS   = 3;
    localparam int DEF_COEF_FRAC  = 10;
    localparam int DEF_ACC_WIDTH  = 26;

    localparam int DEF_SAT_MAX = (1 << (DEF_DATA_WIDTH - 1)) - 1;
    localparam int DEF_SAT_MIN = -(1 << (DEF_DATA_WIDTH - 1));

endpackage

// File: rtl/ffe_round_sat.sv
// Round-half-up and saturate a signed accumulator down to the output width.
// Purely combinational so the serial and parallel FFE variants can share it.
module ffe_round_sat #(
    parameter int ACC_WIDTH  = 26,
    parameter int DATA_WIDTH = 12,
    parameter int COEF_FRAC  = 10
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_in,
    output logic signed [DATA_WIDTH-1:0] data_out
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int SW = ACC_WIDTH + 1;
    localparam logic signed [SW-1:0] HALF = SW'(1) << (COEF_FRAC - 1);
    localparam logic signed [SW-1:0] SMAX = SW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN = ~SMAX;

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] r;

    always_comb begin
        sum = {acc_in[ACC_WIDTH-1], acc_in} + HALF;
        r   = sum >>> COEF_FRAC;
        if (r > SMAX)
            data_out = SMAX[DATA_WIDTH-1:0];
        else if (r < SMIN)
            data_out = SMIN[DATA_WIDTH-1:0];
        else
            data_out = r[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/ffe_tap_sequencer.sv
// Sequences a shared MAC across the FFE taps for every new sample strobe,
// then rounds/saturates the accumulator and pulses data_valid.
module ffe_tap_sequencer
    import ffe_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_TAPS   = DEF_NUM_TAPS,
    parameter int COEF_FRAC  = DEF_COEF_FRAC,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int TAP_W      = $clog2(NUM_TAPS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_in,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic signed [DATA_WIDTH-1:0] sample_out,
    output logic                         shift_en,
    output logic [TAP_W-1:0]             tap_idx,
    output logic                         mac_en,
    output logic                         mac_clr,
    input  logic signed [ACC_WIDTH-1:0]  acc_in,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         data_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

    ffe_state_e state, state_nxt;
    logic       load_in_d;
    logic       start;
    logic       last_tap;
    logic signed [DATA_WIDTH-1:0] rs_out;

    assign start    = load_in & ~load_in_d;
    assign last_tap = (tap_idx == LAST_TAP);

    ffe_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .COEF_FRAC (COEF_FRAC)
    ) u_round_sat (
        .acc_in  (acc_in),
        .data_out(rs_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = SHIFT;
            SHIFT: begin
                shift_en  = 1'b1;
                state_nxt = MAC;
            end
            MAC: begin
                mac_en  = 1'b1;
                mac_clr = (tap_idx == '0);
                if (last_tap) state_nxt = OUT;
            end
            OUT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_in_d  <= 1'b0;
            sample_out <= '0;
            tap_idx    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            load_in_d  <= load_in;
            data_valid <= 1'b0;
            // busy is still high on the edge that leaves OUT, so a start there is dropped too.
            if (start && busy) overrun <= 1'b1;
            if (state == IDLE && start) begin
                sample_out <= data_in;
                busy       <= 1'b1;
            end
            if (state == MAC) tap_idx <= last_tap ? '0 : tap_idx + TAP_W'(1);
            if (state == OUT) begin
                data_out   <= rs_out;
                data_valid <= 1'b1;
                busy       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ffe_tap_sequencer.sv
// Bench for ffe_tap_sequencer: stub MAC, vector table of rounding/saturation
// cases, scoreboard queue of expected outputs, and strobe/reset corner cases.
module tb_ffe_tap_sequencer;

    localparam int DW = 12;
    localparam int NT = 3;
    localparam int CF = 10;
    localparam int AW = 26;
    localparam int TW = $clog2(NT);

    logic                 data_clk_tb = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 load_in = 1'b0;
    logic signed [DW-1:0] data_in = '0;
    logic signed [DW-1:0] sample_out;
    logic                 shift_en;
    logic [TW-1:0]        tap_idx;
    logic                 mac_en;
    logic                 mac_clr;
    logic signed [AW-1:0] acc_in;
    logic signed [DW-1:0] data_out;
    logic                 data_valid;
    logic                 busy;
    logic                 overrun;

    int vectors = 0;
    int miscompares = 0;
    int n_valid = 0;
    int acc_target = 0;
    int exp_q[$];

    always #5 data_clk_tb = ~data_clk_tb;

    ffe_tap_sequencer #(
        .DATA_WIDTH(DW), .NUM_TAPS(NT), .COEF_FRAC(CF), .ACC_WIDTH(AW)
    ) dut (
        .clk(data_clk_tb), .rst_n(rst_n), .load_in(load_in), .data_in(data_in),
        .sample_out(sample_out), .shift_en(shift_en), .tap_idx(tap_idx),
        .mac_en(mac_en), .mac_clr(mac_clr), .acc_in(acc_in),
        .data_out(data_out), .data_valid(data_valid), .busy(busy), .overrun(overrun)
    );

    // Stub MAC: tap 0 loads target-(NT-1), later taps add 1, so the final sum equals the
    // target only if mac_clr lands on tap 0 and every tap accumulates exactly once.
    logic signed [AW-1:0] acc_r;
    logic signed [AW-1:0] prod;
    assign prod   = (tap_idx == '0) ? AW'(acc_target - (NT - 1)) : AW'(1);
    assign acc_in = acc_r;
    always @(posedge data_clk_tb or negedge rst_n) begin
        if (!rst_n)      acc_r <= '0;
        else if (mac_en) acc_r <= mac_clr ? prod : acc_r + prod;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge data_clk_tb) begin
        if (rst_n && data_valid) begin
            n_valid++;
            if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
            else check("data_out", int'(data_out), exp_q.pop_front());
        end
    end

    task automatic run_op(input int d, input int target, input int exp_out);
        @(negedge data_clk_tb);
        acc_target = target;
        data_in    = DW'(d);
        load_in    = 1'b1;
        @(posedge data_clk_tb);
        exp_q.push_back(exp_out);
        @(negedge data_clk_tb);
        load_in = 1'b0;
        check("busy_shift", int'(busy), 1);
        check("sample_out", int'(sample_out), d);
        check("shift_en", int'(shift_en), 1);
        check("mac_en_shift", int'(mac_en), 0);
        for (int t = 0; t < NT; t++) begin
            @(negedge data_clk_tb);
            check("mac_en", int'(mac_en), 1);
            check("tap_idx", int'(tap_idx), t);
            check("mac_clr", int'(mac_clr), (t == 0) ? 1 : 0);
            check("shift_en_mac", int'(shift_en), 0);
        end
        @(negedge data_clk_tb);
        check("mac_en_out", int'(mac_en), 0);
        check("tap_idx_out", int'(tap_idx), 0);
        check("busy_out", int'(busy), 1);
        check("valid_early", int'(data_valid), 0);
        @(negedge data_clk_tb);
        check("valid_pulse", int'(data_valid), 1);
        check("busy_done", int'(busy), 0);
        @(negedge data_clk_tb);
        check("valid_one_cycle", int'(data_valid), 0);
        check("data_out_held", int'(data_out), exp_out);
    endtask

    typedef struct {
        int d;
        int acc;
        int exp_out;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int nv;
        vecs[0]  = '{300,   5120,     5};
        vecs[1]  = '{-7,    1536,     2};
        vecs[2]  = '{2047, -1536,    -1};
        vecs[3]  = '{-2048, 511,      0};
        vecs[4]  = '{1,     512,      1};
        vecs[5]  = '{100,   3000000,  2047};
        vecs[6]  = '{-100, -3000000, -2048};
        vecs[7]  = '{55,    2096639,  2047};
        vecs[8]  = '{56,   -2097664, -2048};
        vecs[9]  = '{57,    33554431, 2047};
        vecs[10] = '{58,   -512,      0};

        #1;
        check("rst_data_out", int'(data_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_valid", int'(data_valid), 0);
        check("rst_sample_out", int'(sample_out), 0);
        check("rst_mac_en", int'(mac_en) + int'(shift_en) + int'(mac_clr) + int'(tap_idx), 0);
        #22 rst_n = 1'b1;
        repeat (10) @(negedge data_clk_tb);
        check("idle_busy", int'(busy), 0);
        check("idle_outs", int'(mac_en) + int'(shift_en) + int'(data_valid), 0);
        check("idle_data_out", int'(data_out), 0);

        foreach (vecs[i]) run_op(vecs[i].d, vecs[i].acc, vecs[i].exp_out);
        check("overrun_clean", int'(overrun), 0);

        // Level held two cycles: one operation only.
        nv = n_valid;
        @(negedge data_clk_tb);
        acc_target = 2048; data_in = 12'sd9; load_in = 1'b1;
        @(posedge data_clk_tb);
        exp_q.push_back(2);
        repeat (2) @(negedge data_clk_tb);
        load_in = 1'b0;
        repeat (10) @(negedge data_clk_tb);
        check("hold2_valids", n_valid - nv, 1);
        check("hold2_overrun", int'(overrun), 0);

        // Second rising edge two cycles after the start is dropped and flagged.
        nv = n_valid;
        @(negedge data_clk_tb);
        acc_target = 3072; data_in = 12'sd11; load_in = 1'b1;
        @(posedge data_clk_tb);
        exp_q.push_back(3);
        @(negedge data_clk_tb);
        load_in = 1'b0;
        @(negedge data_clk_tb);
        data_in = 12'sd77; load_in = 1'b1;
        @(negedge data_clk_tb);
        load_in = 1'b0;
        check("ovr_sample_kept", int'(sample_out), 11);
        repeat (10) @(negedge data_clk_tb);
        check("ovr_valids", n_valid - nv, 1);
        check("ovr_set", int'(overrun), 1);
        run_op(-3, -4096, -4);
        check("ovr_sticky", int'(overrun), 1);

        // Reset in the middle of the MAC phase aborts the sample.
        nv = n_valid;
        @(negedge data_clk_tb);
        acc_target = 9999; data_in = 12'sd33; load_in = 1'b1;
        @(negedge data_clk_tb);
        load_in = 1'b0;
        for (int i = 0; i < 10 && !(mac_en && tap_idx == TW'(1)); i++) @(negedge data_clk_tb);
        check("reach_tap1", int'(mac_en && tap_idx == TW'(1)), 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_mac", int'(mac_en) + int'(mac_clr) + int'(tap_idx) + int'(shift_en), 0);
        check("abort_overrun", int'(overrun), 0);
        check("abort_data", int'(data_out) + int'(sample_out), 0);
        @(negedge data_clk_tb);
        rst_n = 1'b1;
        repeat (8) @(negedge data_clk_tb);
        check("abort_no_valid", n_valid - nv, 0);
        run_op(-1000, -700000, -684);
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
